// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between writeback (priority) and a one-entry parked MDU result; stalls after MAX_WAIT blocked cycles.
// Optional WB_ARB_STATS_EN adds saturating 16-bit event counters (MDU drains, forced stalls, dropped results).
module regfile_write_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        ctrls_w,
  input  logic [DATA_W-1:0] readdata_w,
  input  logic [DATA_W-1:0] aluout_w,
  input  logic [ADDR_W-1:0] writereg_w,
  input  logic              mdu_valid,
  output logic              mdu_ready,
  input  logic [ADDR_W-1:0] mdu_reg,
  input  logic [DATA_W-1:0] mdu_data,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_wa,
  output logic [DATA_W-1:0] rf_wd,
  output logic              stall_req
`ifdef WB_ARB_STATS_EN
  ,
  output logic [15:0]       stat_mdu_writes,
  output logic [15:0]       stat_forced_stalls,
  output logic [15:0]       stat_dropped
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    FORCE = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_LAST = 4'(MAX_WAIT - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] buf_reg_q, buf_reg_d;
  logic [DATA_W-1:0] buf_dat_q, buf_dat_d;
  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_wa_q, rf_wa_d;
  logic [DATA_W-1:0] rf_wd_q, rf_wd_d;

  logic              pipe_wr;
  logic [DATA_W-1:0] pipe_data;
  logic              drain;
  logic              drop;
  logic              force_entry;

  assign pipe_wr   = ctrls_w[1] && (writereg_w != '0);
  assign pipe_data = ctrls_w[0] ? readdata_w : aluout_w;

  always_comb begin
    state_d     = state_q;
    buf_reg_d   = buf_reg_q;
    buf_dat_d   = buf_dat_q;
    wait_cnt_d  = wait_cnt_q;
    rf_we_d     = pipe_wr;
    rf_wa_d     = rf_wa_q;
    rf_wd_d     = rf_wd_q;
    drain       = 1'b0;
    drop        = 1'b0;
    force_entry = 1'b0;

    if (pipe_wr) begin
      rf_wa_d = writereg_w;
      rf_wd_d = pipe_data;
    end

    case (state_q)
      IDLE: begin
        // Results for r0 are acknowledged but never parked.
        if (mdu_valid && (mdu_reg != '0)) begin
          buf_reg_d  = mdu_reg;
          buf_dat_d  = mdu_data;
          wait_cnt_d = '0;
          state_d    = HOLD;
        end
      end
      HOLD, FORCE: begin
        if (pipe_wr && (writereg_w == buf_reg_q)) begin
          // The writeback instruction is younger, so the parked value is stale.
          drop    = 1'b1;
          state_d = IDLE;
        end else if (!pipe_wr) begin
          drain   = 1'b1;
          rf_we_d = 1'b1;
          rf_wa_d = buf_reg_q;
          rf_wd_d = buf_dat_q;
          state_d = IDLE;
        end else if (state_q == HOLD) begin
          if (wait_cnt_q != 4'hF) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
          end
          if (wait_cnt_q == WAIT_LAST) begin
            state_d     = FORCE;
            force_entry = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      buf_reg_q  <= '0;
      buf_dat_q  <= '0;
      wait_cnt_q <= '0;
      rf_we_q    <= 1'b0;
      rf_wa_q    <= '0;
      rf_wd_q    <= '0;
    end else begin
      state_q    <= state_d;
      buf_reg_q  <= buf_reg_d;
      buf_dat_q  <= buf_dat_d;
      wait_cnt_q <= wait_cnt_d;
      rf_we_q    <= rf_we_d;
      rf_wa_q    <= rf_wa_d;
      rf_wd_q    <= rf_wd_d;
    end
  end

  assign mdu_ready = (state_q == IDLE);
  assign stall_req = (state_q == FORCE);
  assign rf_we     = rf_we_q;
  assign rf_wa     = rf_wa_q;
  assign rf_wd     = rf_wd_q;

`ifdef WB_ARB_STATS_EN
  logic [15:0] stat_wr_q, stat_wr_d;
  logic [15:0] stat_fs_q, stat_fs_d;
  logic [15:0] stat_dr_q, stat_dr_d;

  always_comb begin
    stat_wr_d = stat_wr_q;
    stat_fs_d = stat_fs_q;
    stat_dr_d = stat_dr_q;
    if (drain && (stat_wr_q != 16'hFFFF)) stat_wr_d = stat_wr_q + 16'd1;
    if (force_entry && (stat_fs_q != 16'hFFFF)) stat_fs_d = stat_fs_q + 16'd1;
    if (drop && (stat_dr_q != 16'hFFFF)) stat_dr_d = stat_dr_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_wr_q <= '0;
      stat_fs_q <= '0;
      stat_dr_q <= '0;
    end else begin
      stat_wr_q <= stat_wr_d;
      stat_fs_q <= stat_fs_d;
      stat_dr_q <= stat_dr_d;
    end
  end

  assign stat_mdu_writes    = stat_wr_q;
  assign stat_forced_stalls = stat_fs_q;
  assign stat_dropped       = stat_dr_q;
`endif

endmodule
